// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one register set, with tagged handshake result.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out,
  output logic             illegal
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_ready;
  logic             r_busy;
  logic             r_valid;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_rd_out;
  logic             r_illegal;

  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_rd;
  logic             r_neg;
  logic             r_rem_neg;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_ill_op;
  logic             w_is_div;
  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_abs;
  logic [XLEN-1:0]  w_b_abs;
  logic             w_div0;
  logic             w_ovf;
  logic             w_fast;
  logic [XLEN-1:0]  w_fast_res;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_sh;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fix_res;

  assign w_accept = start & r_ready & ~flush;
  assign w_ill_op = (op[2:1] == 2'b01);
  assign w_is_div = op[2];
  assign w_sgn    = ~op[2] | ~op[0];
  assign w_a_neg  = w_sgn & rs1_data[XLEN-1];
  assign w_b_neg  = w_sgn & rs2_data[XLEN-1];
  assign w_a_abs  = w_a_neg ? -rs1_data : rs1_data;
  assign w_b_abs  = w_b_neg ? -rs2_data : rs2_data;
  assign w_div0   = w_is_div & (rs2_data == '0);
  assign w_ovf    = w_is_div & ~op[0]
                  & (rs1_data == INT_MIN)
                  & (&rs2_data);
  assign w_fast   = w_ill_op | w_div0 | w_ovf;

  // op[1] separates remainder results from quotient results
  always_comb begin
    w_fast_res = '0;
    unique case (1'b1)
      w_ill_op: w_fast_res = '0;
      w_div0:   w_fast_res = op[1] ? rs1_data : '1;
      w_ovf:    w_fast_res = op[1] ? '0 : INT_MIN;
      default:  w_fast_res = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : S_ITER;
      S_ITER: if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        if (w_accept) w_next = w_fast ? S_DONE : S_ITER;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE) | (w_next == S_DONE);
      r_busy  <= (w_next == S_ITER) | (w_next == S_FIX);
      r_valid <= (w_next == S_DONE);
    end
  end

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  // partial remainder stays below the divisor, so XLEN bits suffice
  assign w_div_sub = w_div_sh[XLEN-1:0] - r_b;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo_s  = r_neg ? -r_lo : r_lo;
  assign w_rem_s  = r_rem_neg ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    unique case (1'b1)
      (r_op == 3'b000): w_fix_res = w_prod_s[XLEN-1:0];
      (r_op == 3'b001): w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      (r_op[2:1] == 2'b10): w_fix_res = w_quo_s;
      (r_op[2:1] == 2'b11): w_fix_res = w_rem_s;
      default: w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_rd_out  <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op;
      r_rd      <= rd_in;
      r_neg     <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      r_hi      <= '0;
      r_lo      <= w_a_abs;
      r_b       <= w_b_abs;
      r_cnt     <= '0;
      if (w_fast) begin
        r_result  <= w_fast_res;
        r_rd_out  <= rd_in;
        r_illegal <= w_ill_op;
      end
    end else if (r_state == S_ITER) begin
      if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
      if (r_op[2]) begin
        r_hi <= w_div_ge ? w_div_sub : w_div_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (r_state == S_FIX && !flush) begin
      r_result  <= w_fix_res;
      r_rd_out  <= r_rd;
      r_illegal <= 1'b0;
    end
  end

  assign ready        = r_ready;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign result       = r_result;
  assign rd_out       = r_rd_out;
  assign illegal      = r_illegal;

endmodule
